// File: rtl/jtkcpu_mul.sv
// Unsigned shift-add multiplier (MUL 8x8, LMUL 16x16), BPC multiplier bits per cen cycle.
// Result N=(len?16:8)/BPC cen edges after start; start ignored while busy, done pulses for one cen cycle.
module jtkcpu_mul #(
    parameter int BPC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [15:0] op0,
    input  logic [15:0] op1,
    input  logic        len,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] prod,
    output logic        c,
    output logic        z
);

    generate
        if (!(BPC == 1 || BPC == 2 || BPC == 4)) begin : g_bad_bpc
            $error("jtkcpu_mul: BPC must be 1, 2 or 4");
        end
    endgenerate

    localparam int CW = 5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   acc_q, acc_d;
    logic [31:0]   mcand_q, mcand_d;
    logic [15:0]   mplier_q, mplier_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          len_q, len_d;
    logic          done_q, done_d;
    logic [31:0]   prod_q, prod_d;
    logic          c_q, c_d;
    logic          z_q, z_d;

    logic [31:0]   part_sum;
    logic [31:0]   acc_sum;

    // State register: everything advances only on cen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            len_q    <= 1'b0;
            done_q   <= 1'b0;
            prod_q   <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b1;
        end else if (cen) begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            done_q   <= done_d;
            prod_q   <= prod_d;
            c_q      <= c_d;
            z_q      <= z_d;
        end
    end

    // One radix-2^BPC digit: sum of the multiplicand weights selected by the low multiplier bits
    always_comb begin
        part_sum = '0;
        for (int i = 0; i < BPC; i++) begin
            if (mplier_q[i]) begin
                part_sum = part_sum + (mcand_q << i);
            end
        end
        acc_sum = acc_q + part_sum;
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        done_d   = 1'b0;
        prod_d   = prod_q;
        c_d      = c_q;
        z_d      = z_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d    = len;
                    acc_d    = '0;
                    mcand_d  = len ? {16'h0000, op0} : {24'h000000, op0[7:0]};
                    mplier_d = len ? op1 : {8'h00, op1[7:0]};
                    cnt_d    = len ? CW'(16 / BPC) : CW'(8 / BPC);
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << BPC;
                mplier_d = mplier_q >> BPC;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    prod_d  = acc_sum;
                    c_d     = len_q ? acc_sum[15] : acc_sum[7];
                    z_d     = len_q ? (acc_sum == 32'd0) : (acc_sum[15:0] == 16'd0);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q == RUN);
        done = done_q;
        prod = prod_q;
        c    = c_q;
        z    = z_q;
    end

endmodule
